// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, addresses instruction memory and fills the IF/ID register,
// with stall, branch/jump redirect and halt once the PC runs past the end of the program.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 14,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_addr_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic             done_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);
    localparam logic [31:0] END_ADDR = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc4, target;
    logic        capture, bubble;

    assign pc4    = pc + 32'd4;
    assign target = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        bubble    = 1'b0;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (redirect_i) begin
                    pc_nxt    = target;
                    bubble    = 1'b1;
                    state_nxt = (target < END_ADDR) ? RUN : DONE;
                end else if (!stall_i) begin
                    capture   = 1'b1;
                    pc_nxt    = pc4;
                    // compare before the increment so a wrapping pc+4 still halts
                    state_nxt = (pc >= END_ADDR - 32'd4) ? DONE : RUN;
                end
            end
            DONE: begin
                if (redirect_i) begin
                    pc_nxt    = target;
                    bubble    = 1'b1;
                    state_nxt = (target < END_ADDR) ? RUN : DONE;
                end else begin
                    bubble = !stall_i;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= '0;
            ifid_instr_o <= '0;
            ifid_valid_o <= 1'b0;
            fetch_cnt_o  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                ifid_pc_o    <= pc;
                ifid_pc4_o   <= pc4;
                ifid_instr_o <= instr_i;
                ifid_valid_o <= 1'b1;
                fetch_cnt_o  <= (fetch_cnt_o == '1) ? fetch_cnt_o : fetch_cnt_o + 1'b1;
            end else if (bubble) begin
                ifid_pc_o    <= '0;
                ifid_pc4_o   <= '0;
                ifid_instr_o <= '0;
                ifid_valid_o <= 1'b0;
            end
        end
    end

    assign pc_addr_o = pc;
    assign done_o    = (state == DONE);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect traffic checked
// against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;
    localparam int          MW  = 14;
    localparam int          CW  = 4;
    localparam logic [31:0] END = 32'(MW * 4);
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i, stall_i, redirect_i;
    logic [31:0]   redirect_pc_i, instr_i;
    logic [31:0]   pc_addr_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o;
    logic          ifid_valid_o, done_o;
    logic [CW-1:0] fetch_cnt_o;
    logic [31:0]   mem [16];

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid, m_done, m_first;
    int          m_cnt;

    fetch_stage #(.RESET_PC(32'h0), .MEM_WORDS(MW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .instr_i(instr_i), .pc_addr_o(pc_addr_o),
        .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o), .done_o(done_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb instr_i = (pc_addr_o < END) ? mem[pc_addr_o[5:2]] : 32'h0;

    task automatic reset_model();
        m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0;
        m_valid = 0; m_done = 0; m_first = 1; m_cnt = 0;
    endtask

    // one clock: drive inputs, advance the model at the edge, settle 1 time unit
    task automatic tick(input logic s, input logic r, input logic [31:0] t);
        logic [31:0] ta;
        stall_i = s; redirect_i = r; redirect_pc_i = t;
        @(posedge clk_i);
        ta = t & 32'hFFFF_FFFC;
        if (m_first) m_first = 0;
        else if (r) begin
            m_pc = ta; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0;
            m_done = (ta >= END);
        end else if (s) begin
        end else if (m_done) begin
            m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_valid = 0;
        end else begin
            m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_instr = (m_pc < END) ? mem[m_pc[5:2]] : 32'h0;
            m_valid = 1;
            if (m_cnt < CMAX) m_cnt++;
            m_done = ({1'b0, m_pc} + 33'd4) >= {1'b0, END};
            m_pc = m_pc + 4;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        @(posedge clk_i); #1;
        reset_model();
        rst_i = 1;
    endtask

    task automatic test_reset();
        rst_i = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        #12;
        checks++; if (pc_addr_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_addr_o); end
        checks++; if ({ifid_pc_o, ifid_pc4_o, ifid_instr_o} !== 96'h0) begin errors++; $display("FAIL reset_ifid got=%h/%h/%h exp=0", ifid_pc_o, ifid_pc4_o, ifid_instr_o); end
        checks++; if ({ifid_valid_o, done_o} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ifid_valid_o, done_o); end
        checks++; if (fetch_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt_o); end
        @(posedge clk_i); #1;
        reset_model();
        rst_i = 1;
    endtask

    task automatic test_free_run();
        tick(0, 0, 0);
        checks++; if (pc_addr_o !== 32'h0 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL idle_cycle got pc=%h v=%b exp pc=0 v=0", pc_addr_o, ifid_valid_o); end
        tick(0, 0, 0);
        checks++; if ({ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o} !== {32'h0, 32'h4, mem[0], 1'b1}) begin errors++; $display("FAIL first_capture got=%h/%h/%h/%b exp=0/4/%h/1", ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, mem[0]); end
        tick(0, 0, 0);
        checks++; if ({ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o} !== {32'h4, 32'h8, mem[1], 1'b1}) begin errors++; $display("FAIL second_capture got=%h/%h/%h/%b exp=4/8/%h/1", ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, mem[1]); end
        checks++; if (fetch_cnt_o !== CW'(2) || pc_addr_o !== 32'h8) begin errors++; $display("FAIL free_run_cnt got cnt=%0d pc=%h exp cnt=2 pc=8", fetch_cnt_o, pc_addr_o); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0);
            checks++; if (pc_addr_o !== 32'h8 || ifid_pc_o !== 32'h4 || ifid_instr_o !== mem[1] || ifid_valid_o !== 1'b1 || fetch_cnt_o !== CW'(2)) begin
                errors++; $display("FAIL stall_hold%0d got pc=%h ifid_pc=%h instr=%h v=%b cnt=%0d exp pc=8 ifid_pc=4 instr=%h v=1 cnt=2", i, pc_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_cnt_o, mem[1]);
            end
        end
    endtask

    task automatic test_redirect();
        tick(0, 0, 0);
        tick(0, 0, 0);
        checks++; if (pc_addr_o !== 32'h10) begin errors++; $display("FAIL pre_redirect_pc got=%h exp=10", pc_addr_o); end
        tick(0, 1, 32'h1E);
        checks++; if (pc_addr_o !== 32'h1C || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc_o !== 32'h0) begin errors++; $display("FAIL redirect_misaligned got pc=%h v=%b instr=%h ipc=%h exp pc=1c v=0 instr=0 ipc=0", pc_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o); end
        checks++; if (fetch_cnt_o !== CW'(4)) begin errors++; $display("FAIL redirect_cnt got=%0d exp=4", fetch_cnt_o); end
    endtask

    task automatic test_redirect_stall();
        tick(1, 1, 32'h4);
        checks++; if (pc_addr_o !== 32'h4 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0) begin errors++; $display("FAIL redirect_beats_stall got pc=%h v=%b instr=%h exp pc=4 v=0 instr=0", pc_addr_o, ifid_valid_o, ifid_instr_o); end
        tick(0, 0, 0);
        checks++; if (ifid_pc_o !== 32'h4 || ifid_instr_o !== mem[1] || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL after_redirect got ipc=%h instr=%h v=%b exp ipc=4 instr=%h v=1", ifid_pc_o, ifid_instr_o, ifid_valid_o, mem[1]); end
    endtask

    task automatic test_done();
        apply_reset();
        tick(0, 0, 0);
        for (int i = 0; i < 30 && done_o !== 1'b1; i++) tick(0, 0, 0);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL done_timeout got=%b exp=1", done_o); end
        checks++; if (ifid_pc_o !== 32'h34 || ifid_instr_o !== mem[13] || ifid_valid_o !== 1'b1 || pc_addr_o !== 32'h38) begin errors++; $display("FAIL last_word got ipc=%h instr=%h v=%b pc=%h exp ipc=34 instr=%h v=1 pc=38", ifid_pc_o, ifid_instr_o, ifid_valid_o, pc_addr_o, mem[13]); end
        checks++; if (fetch_cnt_o !== CW'(14)) begin errors++; $display("FAIL done_cnt got=%0d exp=14", fetch_cnt_o); end
        tick(0, 0, 0);
        checks++; if (done_o !== 1'b1 || ifid_valid_o !== 1'b0 || pc_addr_o !== 32'h38 || fetch_cnt_o !== CW'(14)) begin errors++; $display("FAIL done_hold got done=%b v=%b pc=%h cnt=%0d exp done=1 v=0 pc=38 cnt=14", done_o, ifid_valid_o, pc_addr_o, fetch_cnt_o); end
        tick(0, 1, 32'h40);
        checks++; if (done_o !== 1'b1 || pc_addr_o !== 32'h40) begin errors++; $display("FAIL done_far_redirect got done=%b pc=%h exp done=1 pc=40", done_o, pc_addr_o); end
        tick(0, 1, 32'h0);
        checks++; if (done_o !== 1'b0 || pc_addr_o !== 32'h0) begin errors++; $display("FAIL resume got done=%b pc=%h exp done=0 pc=0", done_o, pc_addr_o); end
        tick(0, 0, 0);
        checks++; if (ifid_instr_o !== mem[0] || ifid_valid_o !== 1'b1 || fetch_cnt_o !== CW'(15)) begin errors++; $display("FAIL resume_fetch got instr=%h v=%b cnt=%0d exp instr=%h v=1 cnt=15", ifid_instr_o, ifid_valid_o, fetch_cnt_o, mem[0]); end
        tick(0, 0, 0);
        checks++; if (fetch_cnt_o !== CW'(15)) begin errors++; $display("FAIL cnt_saturate got=%0d exp=15", fetch_cnt_o); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        redirect_i = 1; redirect_pc_i = 32'h20;
        #2 rst_i = 0;
        #1;
        checks++; if (pc_addr_o !== 32'h0 || ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || fetch_cnt_o !== '0 || done_o !== 1'b0) begin errors++; $display("FAIL async_reset got pc=%h v=%b instr=%h cnt=%0d done=%b exp all 0", pc_addr_o, ifid_valid_o, ifid_instr_o, fetch_cnt_o, done_o); end
        @(posedge clk_i); #1;
        reset_model();
        rst_i = 1;
        tick(0, 1, 32'h20);
        checks++; if (pc_addr_o !== 32'h0 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL idle_ignores_redirect got pc=%h v=%b exp pc=0 v=0", pc_addr_o, ifid_valid_o); end
        tick(0, 0, 0);
        checks++; if (ifid_instr_o !== mem[0] || pc_addr_o !== 32'h4) begin errors++; $display("FAIL post_reset_fetch got instr=%h pc=%h exp instr=%h pc=4", ifid_instr_o, pc_addr_o, mem[0]); end
    endtask

    task automatic test_random();
        logic        s, r;
        logic [31:0] t;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h50));
            tick(s, r, t);
            checks++;
            if (pc_addr_o !== m_pc || ifid_pc_o !== m_ipc || ifid_pc4_o !== m_ipc4 || ifid_instr_o !== m_instr ||
                ifid_valid_o !== m_valid || done_o !== m_done || fetch_cnt_o !== CW'(m_cnt)) begin
                errors++;
                $display("FAIL rnd%0d got pc=%h %h/%h/%h v=%b d=%b c=%0d exp pc=%h %h/%h/%h v=%b d=%b c=%0d", i,
                         pc_addr_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, done_o, fetch_cnt_o,
                         m_pc, m_ipc, m_ipc4, m_instr, m_valid, m_done, m_cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_done();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
